ber_checker: RTL and testbench
==============================

BER_CHECKER -- requirements
Module: ber_checker

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32: width of the bit and error counters.
REQ-002 The block SHALL have parameter LOCK_LEN, default 32: number of consecutive correct predictions required to lock.
REQ-003 The block SHALL have parameter WIN_LEN, default 128: resync observation window in bits.
REQ-004 The block SHALL have parameter RESYNC_THR, default 16: number of errors within one window that forces a resync.
REQ-005 The block SHALL have port clk, input, 1 bit: clock.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port i_enable, input, 1 bit: qualifies i_bit for the current cycle.
REQ-008 The block SHALL have port i_bit, input, 1 bit: received PRBS9 bit.
REQ-009 The block SHALL have port i_clr_cnt, input, 1 bit: clears the counters.
REQ-010 The block SHALL have port o_lock, output, 1 bit: high while in state LOCKED.
REQ-011 The block SHALL have port o_err, output, 1 bit: one-cycle pulse for each mismatched bit while locked.
REQ-012 The block SHALL have port o_bit_cnt, output, CNT_W bits: number of bits checked while locked.
REQ-013 The block SHALL have port o_err_cnt, output, CNT_W bits: number of errored bits while locked.

Function
REQ-014 The block SHALL check the sequence defined by x[n] = x[n-9] XOR x[n-5], that is, PRBS9 with taps 9 and 5.
REQ-015 The block SHALL implement a two-state FSM with states SEARCH and LOCKED.
REQ-016 The block SHALL leave all state unchanged in any cycle where i_enable = 0, except that i_clr_cnt SHALL still take effect.
REQ-017 In SEARCH, the block SHALL shift each enabled i_bit into a 9-bit history and increment a fill count that saturates at 9.
REQ-018 In SEARCH with the fill count at 9, the predicted bit SHALL be history[n-9] XOR history[n-5].
REQ-019 In SEARCH, a prediction that matches SHALL increment the match count; a mismatch SHALL clear it to 0.
REQ-020 The block SHALL treat an all-zero history as a mismatch, so it never locks on a stuck-at-0 stream.
REQ-021 When the match count reaches LOCK_LEN, the FSM SHALL move to LOCKED, with o_lock going high on the following edge.
REQ-022 In LOCKED, the history SHALL be fed with predicted bits, not received bits, so that one flipped input bit yields exactly one error.
REQ-023 In LOCKED, each enabled bit SHALL increment o_bit_cnt, and each mismatch SHALL increment o_err_cnt and assert o_err.
REQ-024 o_err SHALL be registered: it is high in the cycle after the enabled errored bit, for one cycle only.
REQ-025 Both counters SHALL saturate at all-ones and SHALL not wrap.
REQ-026 i_clr_cnt SHALL zero both counters on the next edge, and it SHALL win over a simultaneous increment.
REQ-027 i_clr_cnt SHALL not affect the FSM state or o_lock.
REQ-028 Counters SHALL hold their values when leaving LOCKED.

Reset
REQ-029 On rst, the FSM SHALL go to SEARCH, and the history, fill count, match count and window counters SHALL be cleared to 0.
REQ-030 On rst, o_lock, o_err, o_bit_cnt and o_err_cnt SHALL be cleared to 0.
REQ-031 rst SHALL take priority over i_enable and i_clr_cnt.
REQ-032 rst asserted mid-lock SHALL drop o_lock on the next edge.

Configuration
REQ-033 With macro BER_AUTO_RESYNC_EN defined, the block SHALL count enabled bits and errors in LOCKED over consecutive WIN_LEN-bit windows.
REQ-034 With BER_AUTO_RESYNC_EN defined, when the window error count reaches RESYNC_THR, the FSM SHALL return to SEARCH with the fill and match counts cleared.
REQ-035 With BER_AUTO_RESYNC_EN defined, the window counters SHALL restart at every window boundary and on every entry to LOCKED.
REQ-036 With BER_AUTO_RESYNC_EN undefined, the window logic SHALL be absent and LOCKED SHALL be left only via rst.

Structure
REQ-037 The shared package qpsk_pkg SHALL hold PRBS9_LEN = 9, the tap positions 9 and 5, and the FSM state encoding.
REQ-038 The block SHALL contain one sub-module, ber_ref_lfsr: a 9-bit history with a selectable feed (received or predicted) and a predicted-bit output.

Verification
REQ-039 Bench SHALL cover: stream from prbs9 with SEED = 9'h1FF, enable every cycle -> o_lock high after 9 + LOCK_LEN enables; o_err_cnt = 0 and o_bit_cnt = 1000 after 1000 locked bits.
REQ-040 Bench SHALL cover: once locked, a single bit inverted -> exactly one o_err pulse and o_err_cnt = 1.
REQ-041 Bench SHALL cover: constant-zero stream for 500 enables -> o_lock stays 0.
REQ-042 Bench SHALL cover: i_clr_cnt asserted in the same cycle as an errored enabled bit -> both counters read 0 and o_lock stays 1.
REQ-043 Bench SHALL cover: CNT_W = 4, locked with all bits inverted for 20 bits -> o_err_cnt saturates at 15 when the macro is undefined.
REQ-044 Bench SHALL cover: with BER_AUTO_RESYNC_EN, 16 errors within 128 bits -> o_lock drops, then relocks within 9 + LOCK_LEN clean bits.

Source files
------------

// File: rtl/qpsk_pkg.sv
// Shared constants for the PRBS9 bit-error-rate checker:
// sequence length, recurrence taps and FSM state encoding.
package qpsk_pkg;

  localparam int PRBS9_LEN = 9;
  localparam int TAP_A     = 9;
  localparam int TAP_B     = 5;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } ber_state_t;

endpackage

// File: rtl/ber_ref_lfsr.sv
// PRBS9 reference history: 9-bit shift register fed either by
// the received bit or by its own prediction.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   shift     - advance the history by one bit
//   sel_pred  - 1: feed predicted bit, 0: feed rx_bit
//   rx_bit    - received bit
//   pred      - predicted next bit x[n-9] ^ x[n-5]
//   hist_zero - history is all zero
module ber_ref_lfsr
  import qpsk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic shift,
  input  logic sel_pred,
  input  logic rx_bit,
  output logic pred,
  output logic hist_zero
);

  // hist[0] is the newest bit, hist[k] is x[n-1-k]
  logic [PRBS9_LEN-1:0] hist;
  logic                 feed;

  assign pred      = hist[TAP_A-1] ^ hist[TAP_B-1];
  assign hist_zero = (hist == '0);
  assign feed      = sel_pred ? pred : rx_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '0;
    end else if (shift) begin
      hist <= {hist[PRBS9_LEN-2:0], feed};
    end
  end

endmodule

// File: rtl/ber_checker.sv
// PRBS9 bit-error-rate checker: searches for lock on the
// received stream, then counts checked and errored bits.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   i_enable    - qualifies i_bit this cycle
//   i_bit       - received PRBS9 bit
//   i_clr_cnt   - zero both counters (wins over increments)
//   o_lock      - high while LOCKED
//   o_err       - registered one-cycle pulse per errored bit
//   o_bit_cnt   - saturating count of bits checked in lock
//   o_err_cnt   - saturating count of errored bits in lock
// Optional: define BER_AUTO_RESYNC_EN to drop back to SEARCH
// when RESYNC_THR errors fall inside one WIN_LEN-bit window.
module ber_checker
  import qpsk_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int LOCK_LEN   = 32,
  parameter int WIN_LEN    = 128,
  parameter int RESYNC_THR = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_bit,
  input  logic             i_clr_cnt,
  output logic             o_lock,
  output logic             o_err,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam int MW = $clog2(LOCK_LEN + 1);

  if (LOCK_LEN < 1 || WIN_LEN < 1 || RESYNC_THR < 1)
  begin : g_bad_param
    $error("ber_checker: parameters must be >= 1");
  end

  ber_state_t state;
  ber_state_t state_next;

  logic [3:0]    fill;
  logic [MW-1:0] match_cnt;

  logic pred;
  logic hist_zero;
  logic mismatch;
  logic fill_full;
  logic good;
  logic lock_hit;
  logic resync_hit;

  logic locked;
  logic check;
  logic err_hit;

  ber_ref_lfsr u_ref (
    .clk       (clk),
    .rst       (rst),
    .shift     (i_enable),
    .sel_pred  (locked),
    .rx_bit    (i_bit),
    .pred      (pred),
    .hist_zero (hist_zero)
  );

  assign mismatch  = (pred != i_bit);
  assign fill_full = (fill == 4'(PRBS9_LEN));
  // a zero history predicts zero forever; never count it as a match
  assign good      = fill_full && !mismatch && !hist_zero;
  assign lock_hit  = (state == SEARCH) && i_enable && good &&
                     (match_cnt == MW'(LOCK_LEN - 1));

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEARCH;
    end else begin
      state <= state_next;
    end
  end

  // next state
  always_comb begin
    state_next = state;
    unique case (state)
      SEARCH: if (lock_hit) state_next = LOCKED;
      LOCKED: if (resync_hit) state_next = SEARCH;
      default: state_next = SEARCH;
    endcase
  end

  // outputs / datapath controls
  always_comb begin
    locked  = (state == LOCKED);
    check   = locked && i_enable;
    err_hit = check && mismatch;
  end

  assign o_lock = locked;

  always_ff @(posedge clk) begin
    if (rst) begin
      fill      <= '0;
      match_cnt <= '0;
    end else if (resync_hit) begin
      fill      <= '0;
      match_cnt <= '0;
    end else if (i_enable && state == SEARCH) begin
      if (!fill_full) fill <= fill + 4'd1;
      if (good) match_cnt <= match_cnt + MW'(1);
      else      match_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_err <= 1'b0;
    end else begin
      o_err <= err_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr_cnt) begin
      o_bit_cnt <= '0;
      o_err_cnt <= '0;
    end else begin
      if (check && !(&o_bit_cnt))
        o_bit_cnt <= o_bit_cnt + CNT_W'(1);
      if (err_hit && !(&o_err_cnt))
        o_err_cnt <= o_err_cnt + CNT_W'(1);
    end
  end

`ifdef BER_AUTO_RESYNC_EN
  localparam int WW = $clog2(WIN_LEN + 1);
  localparam int EW = $clog2(RESYNC_THR + 1);

  logic [WW-1:0] win_bits;
  logic [EW-1:0] win_errs;

  assign resync_hit = err_hit &&
                      (win_errs == EW'(RESYNC_THR - 1));

  always_ff @(posedge clk) begin
    if (rst || lock_hit) begin
      win_bits <= '0;
      win_errs <= '0;
    end else if (check) begin
      if (resync_hit ||
          win_bits == WW'(WIN_LEN - 1)) begin
        win_bits <= '0;
        win_errs <= '0;
      end else begin
        win_bits <= win_bits + WW'(1);
        if (err_hit) win_errs <= win_errs + EW'(1);
      end
    end
  end
`else
  assign resync_hit = 1'b0;
`endif

endmodule

// File: tb/tb_ber_checker.sv
// Directed bench for ber_checker: lock, error counting, clear,
// stuck-zero rejection, saturation and optional resync.
module tb_ber_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic bi  = 1'b0;
  logic clr = 1'b0;

  logic        lock;
  logic        err;
  logic [31:0] bcnt;
  logic [31:0] ecnt;
  logic        s_lock;
  logic        s_err;
  logic [3:0]  s_bcnt;
  logic [3:0]  s_ecnt;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [8:0] g;

  always #5 clk = ~clk;

  ber_checker dut (
    .clk       (clk),
    .rst       (rst),
    .i_enable  (en),
    .i_bit     (bi),
    .i_clr_cnt (clr),
    .o_lock    (lock),
    .o_err     (err),
    .o_bit_cnt (bcnt),
    .o_err_cnt (ecnt)
  );

  ber_checker #(.CNT_W(4)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .i_enable  (en),
    .i_bit     (bi),
    .i_clr_cnt (clr),
    .o_lock    (s_lock),
    .o_err     (s_err),
    .o_bit_cnt (s_bcnt),
    .o_err_cnt (s_ecnt)
  );

  task automatic step(input logic e, input logic b,
                      input logic c);
    en  = e;
    bi  = b;
    clr = c;
    @(posedge clk);
    #1;
    if (err) pulses++;
  endtask

  // reference PRBS9: g[8] is the oldest bit, output first
  task automatic next_bit(output logic b);
    b = g[8];
    g = {g[7:0], g[8] ^ g[4]};
  endtask

  task automatic send_prbs(input int n, input logic inv);
    logic b;
    for (int i = 0; i < n; i++) begin
      next_bit(b);
      step(1'b1, b ^ inv, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    checks++;
    if (lock !== 1'b0) begin
      errors++;
      $display("FAIL reset_lock: got %0b want 0", lock);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %0b want 0", err);
    end
    checks++;
    if (bcnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_bcnt: got %0d want 0", bcnt);
    end
    checks++;
    if (ecnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_ecnt: got %0d want 0", ecnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_lock();
    logic b;
    int n;
    int i;
    g = 9'h1FF;
    send_prbs(40, 1'b0);
    checks++;
    if (lock !== 1'b0) begin
      errors++;
      $display("FAIL lock_early_40: got %0b want 0", lock);
    end
    send_prbs(1, 1'b0);
    checks++;
    if (lock !== 1'b1) begin
      errors++;
      $display("FAIL lock_at_41: got %0b want 1", lock);
    end
    pulses = 0;
    n = 0;
    i = 0;
    while (n < 1000) begin
      if (i % 7 == 6) begin
        step(1'b0, 1'($urandom), 1'b0);
      end else begin
        next_bit(b);
        step(1'b1, b, 1'b0);
        n++;
      end
      i++;
    end
    checks++;
    if (bcnt !== 32'd1000) begin
      errors++;
      $display("FAIL clean_bcnt: got %0d want 1000", bcnt);
    end
    checks++;
    if (ecnt !== 32'd0) begin
      errors++;
      $display("FAIL clean_ecnt: got %0d want 0", ecnt);
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL clean_pulses: got %0d want 0", pulses);
    end
  endtask

  task automatic test_single_err();
    pulses = 0;
    send_prbs(1, 1'b1);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_pulse: got %0b want 1", err);
    end
    send_prbs(50, 1'b0);
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL err_pulses: got %0d want 1", pulses);
    end
    checks++;
    if (ecnt !== 32'd1) begin
      errors++;
      $display("FAIL err_ecnt: got %0d want 1", ecnt);
    end
    checks++;
    if (bcnt !== 32'd1051) begin
      errors++;
      $display("FAIL err_bcnt: got %0d want 1051", bcnt);
    end
  endtask

  task automatic test_clr();
    logic b;
    next_bit(b);
    step(1'b1, ~b, 1'b1);
    checks++;
    if (bcnt !== 32'd0 || ecnt !== 32'd0) begin
      errors++;
      $display("FAIL clr_cnts: got %0d/%0d want 0/0",
               bcnt, ecnt);
    end
    checks++;
    if (lock !== 1'b1) begin
      errors++;
      $display("FAIL clr_lock: got %0b want 1", lock);
    end
    send_prbs(3, 1'b0);
    checks++;
    if (bcnt !== 32'd3) begin
      errors++;
      $display("FAIL clr_recount: got %0d want 3", bcnt);
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (bcnt !== 32'd0) begin
      errors++;
      $display("FAIL clr_idle: got %0d want 0", bcnt);
    end
  endtask

  task automatic test_zero();
    int seen;
    do_reset();
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (lock) seen++;
    end
    checks++;
    if (seen != 0 || lock !== 1'b0) begin
      errors++;
      $display("FAIL zero_lock: got %0d locked cycles want 0",
               seen);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    g = 9'h1FF;
    send_prbs(41, 1'b0);
    checks++;
    if (s_lock !== 1'b1) begin
      errors++;
      $display("FAIL sat_lock: got %0b want 1", s_lock);
    end
    send_prbs(20, 1'b1);
    checks++;
    if (s_ecnt !== 4'd15 || s_bcnt !== 4'd15) begin
      errors++;
      $display("FAIL sat_cnts: got %0d/%0d want 15/15",
               s_ecnt, s_bcnt);
    end
    checks++;
    if (ecnt !== 32'd20) begin
      errors++;
      $display("FAIL sat_wide_ecnt: got %0d want 20", ecnt);
    end
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    checks++;
    if (lock !== 1'b0 || s_lock !== 1'b0) begin
      errors++;
      $display("FAIL rst_midlock: got %0b/%0b want 0/0",
               lock, s_lock);
    end
  endtask

  task automatic test_resync();
    do_reset();
    g = 9'h1FF;
    send_prbs(41, 1'b0);
    checks++;
    if (lock !== 1'b1) begin
      errors++;
      $display("FAIL rs_lock: got %0b want 1", lock);
    end
    send_prbs(15, 1'b1);
    checks++;
    if (lock !== 1'b1) begin
      errors++;
      $display("FAIL rs_hold15: got %0b want 1", lock);
    end
    send_prbs(1, 1'b1);
    checks++;
    if (lock !== 1'b0) begin
      errors++;
      $display("FAIL rs_drop: got %0b want 0", lock);
    end
    checks++;
    if (ecnt !== 32'd16) begin
      errors++;
      $display("FAIL rs_ecnt_hold: got %0d want 16", ecnt);
    end
    send_prbs(40, 1'b0);
    checks++;
    if (lock !== 1'b0) begin
      errors++;
      $display("FAIL rs_early: got %0b want 0", lock);
    end
    send_prbs(1, 1'b0);
    checks++;
    if (lock !== 1'b1) begin
      errors++;
      $display("FAIL rs_relock: got %0b want 1", lock);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_err();
    test_clr();
    test_zero();
`ifdef BER_AUTO_RESYNC_EN
    test_resync();
`else
    test_saturate();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
